// File: rtl/operand_sequencer.sv
// Operand stimulus generator: drives a packed operand bus frame by frame for power/activity runs.
// Latency: start sampled at edge t gives frame 0 on the bus in cycle t+1; every output is a register.
// Backpressure: none; the sequencer free-runs once started and only abort or reset can stop it.
//
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   start, abort  run control (start honoured in IDLE only, abort in RUN/DONE)
//   mode, seed    operand source and LFSR seed / constant, captured with start
//   operands      OPERAND_COUNT x OPERAND_WIDTH packed bus, operand k at [k*W +: W]
//   frame_valid   first cycle of every frame
//   frame_idx     index of the frame currently on the bus
//   busy, done    run in progress / one-cycle pulse after the last frame
module operand_sequencer #(
    parameter int FRAME_COUNT   = 1,
    parameter int OPERAND_COUNT = 2,
    parameter int OPERAND_WIDTH = 32,
    parameter int HOLD_CYCLES   = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic                                   abort,
    input  logic [1:0]                             mode,
    input  logic [31:0]                            seed,
    output logic [OPERAND_COUNT*OPERAND_WIDTH-1:0] operands,
    output logic                                   frame_valid,
    output logic [15:0]                            frame_idx,
    output logic                                   busy,
    output logic                                   done
);

    localparam int          BUS_W     = OPERAND_COUNT * OPERAND_WIDTH;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         hold_q, hold_d;
    logic [15:0]        frame_q, frame_d;
    logic [1:0]         mode_q, mode_d;
    logic [31:0]        seed_q, seed_d;
    logic [31:0]        lfsr_q [OPERAND_COUNT];
    logic [31:0]        lfsr_d [OPERAND_COUNT];
    logic [BUS_W-1:0]   ops_q, ops_d, ops_next;
    logic               fv_q, fv_d;
    logic               load_ops;
    logic               clear_ops;
    logic [31:0]        seed_nz;

    // Galois right-shift step: the outgoing LSB decides whether the taps are applied.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] v, input int unsigned r);
        int unsigned rr;
        rr = r % 32;
        if (rr == 0) begin
            return v;
        end
        return (v << rr) | (v >> (32 - rr));
    endfunction

    function automatic logic [31:0] operand_val(
        input logic [1:0]  m,
        input logic [15:0] n,
        input int unsigned k,
        input logic [31:0] l,
        input logic [31:0] s
    );
        case (m)
            2'd1:    return 32'(n) + 32'(k);
            2'd2:    return l;
            2'd3:    return s;
            default: return 32'd0;
        endcase
    endfunction

    // An all-zero seed would lock the LFSR at zero forever.
    assign seed_nz = (seed == 32'd0) ? 32'd1 : seed;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            frame_q <= '0;
            mode_q  <= '0;
            seed_q  <= '0;
            ops_q   <= '0;
            fv_q    <= 1'b0;
            for (int k = 0; k < OPERAND_COUNT; k++) begin
                lfsr_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            frame_q <= frame_d;
            mode_q  <= mode_d;
            seed_q  <= seed_d;
            ops_q   <= ops_d;
            fv_q    <= fv_d;
            for (int k = 0; k < OPERAND_COUNT; k++) begin
                lfsr_q[k] <= lfsr_d[k];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        frame_d   = frame_q;
        mode_d    = mode_q;
        seed_d    = seed_q;
        fv_d      = 1'b0;
        load_ops  = 1'b0;
        clear_ops = 1'b0;
        for (int k = 0; k < OPERAND_COUNT; k++) begin
            lfsr_d[k] = lfsr_q[k];
        end

        case (state_q)
            IDLE: begin
                // start wins over a simultaneous abort here: abort has nothing to stop.
                if (start) begin
                    state_d  = RUN;
                    hold_d   = '0;
                    frame_d  = '0;
                    mode_d   = mode;
                    seed_d   = seed;
                    fv_d     = 1'b1;
                    load_ops = 1'b1;
                    for (int k = 0; k < OPERAND_COUNT; k++) begin
                        lfsr_d[k] = rotl32(seed_nz, k);
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d   = IDLE;
                    hold_d    = '0;
                    frame_d   = '0;
                    clear_ops = 1'b1;
                end else if (hold_q == 8'(HOLD_CYCLES - 1)) begin
                    if (frame_q == 16'(FRAME_COUNT - 1)) begin
                        // Operands and frame_idx stay on the last frame through DONE.
                        state_d = DONE;
                        hold_d  = '0;
                    end else begin
                        frame_d  = frame_q + 16'd1;
                        hold_d   = '0;
                        fv_d     = 1'b1;
                        load_ops = 1'b1;
                        for (int k = 0; k < OPERAND_COUNT; k++) begin
                            lfsr_d[k] = lfsr_step(lfsr_q[k]);
                        end
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            DONE: begin
                // DONE always falls back to IDLE; abort here only suppresses nothing further.
                state_d   = IDLE;
                hold_d    = '0;
                frame_d   = '0;
                clear_ops = 1'b1;
            end
            default: begin
                state_d   = IDLE;
                hold_d    = '0;
                frame_d   = '0;
                clear_ops = 1'b1;
            end
        endcase
    end

    // Operand set for the frame being entered, built from the next-state values so
    // the bus changes on the same edge as frame_idx.
    always_comb begin
        ops_next = '0;
        for (int k = 0; k < OPERAND_COUNT; k++) begin
            ops_next[k*OPERAND_WIDTH +: OPERAND_WIDTH] =
                OPERAND_WIDTH'(operand_val(mode_d, frame_d, k, lfsr_d[k], seed_d));
        end
    end

    always_comb begin
        ops_d = ops_q;
        if (clear_ops) begin
            ops_d = '0;
        end else if (load_ops) begin
            ops_d = ops_next;
        end
    end

    assign operands    = ops_q;
    assign frame_valid = fv_q;
    assign frame_idx   = frame_q;
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_operand_sequencer.sv
module tb_operand_sequencer;

    localparam int FC = 4;
    localparam int HC = 2;
    localparam int OC = 2;
    localparam int OW = 16;
    localparam int BW = OC * OW;
    localparam logic [31:0] MASK = 32'h8020_0003;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [31:0]   seed = 32'd0;
    logic [BW-1:0] operands;
    logic          frame_valid;
    logic [15:0]   frame_idx;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    operand_sequencer #(
        .FRAME_COUNT  (FC),
        .OPERAND_COUNT(OC),
        .OPERAND_WIDTH(OW),
        .HOLD_CYCLES  (HC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .mode       (mode),
        .seed       (seed),
        .operands   (operands),
        .frame_valid(frame_valid),
        .frame_idx  (frame_idx),
        .busy       (busy),
        .done       (done)
    );

    typedef struct packed {
        logic [BW-1:0] ops;
        logic          fv;
        logic [15:0]   idx;
        logic          busy;
        logic          done;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    // Reference model: a run is described only by "cycles elapsed since start".
    bit          m_active = 1'b0;
    int          m_el = 0;
    logic [1:0]  m_mode = 2'd0;
    logic [31:0] m_seed = 32'd0;

    function automatic logic [31:0] lfsr_at(input logic [31:0] s, input int k, input int n);
        logic [31:0] x;
        int r;
        x = (s == 32'd0) ? 32'd1 : s;
        r = k % 32;
        if (r != 0) x = (x << r) | (x >> (32 - r));
        for (int i = 0; i < n; i++) begin
            x = x[0] ? ((x >> 1) ^ MASK) : (x >> 1);
        end
        return x;
    endfunction

    function automatic logic [BW-1:0] frame_ops(input int n);
        logic [BW-1:0] o;
        logic [31:0]   v;
        o = '0;
        for (int k = 0; k < OC; k++) begin
            case (m_mode)
                2'd1:    v = 32'(n + k);
                2'd2:    v = lfsr_at(m_seed, k, n);
                2'd3:    v = m_seed;
                default: v = 32'd0;
            endcase
            o[k*OW +: OW] = v[OW-1:0];
        end
        return o;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e = '0;
        if (m_active) begin
            if (m_el < FC * HC) begin
                e.ops  = frame_ops(m_el / HC);
                e.fv   = (m_el % HC) == 0;
                e.idx  = 16'(m_el / HC);
                e.busy = 1'b1;
            end else begin
                e.ops  = frame_ops(FC - 1);
                e.idx  = 16'(FC - 1);
                e.done = 1'b1;
            end
        end
        return e;
    endfunction

    // Model advances on the same edge the DUT samples its inputs, then queues
    // what the outputs must be for the coming cycle.
    always @(posedge clk) begin
        if (reset) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1;
                m_el     = 0;
                m_mode   = mode;
                m_seed   = seed;
            end
        end else if (abort || m_el == FC * HC) begin
            m_active = 1'b0;
        end else begin
            m_el = m_el + 1;
        end
        expq.push_back(model_out());
        mon_en = 1'b1;
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty cyc=%0d got=none expected=entry", cyc);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("operands",    64'(operands),    64'(e.ops));
                chk("frame_valid", 64'(frame_valid), 64'(e.fv));
                chk("frame_idx",   64'(frame_idx),   64'(e.idx));
                chk("busy",        64'(busy),        64'(e.busy));
                chk("done",        64'(done),        64'(e.done));
            end
        end
    end

    task automatic drv(input int n, input bit rst, input bit st, input bit ab,
                       input logic [1:0] md, input logic [31:0] sd);
        repeat (n) begin
            @(negedge clk);
            reset = rst;
            start = st;
            abort = ab;
            mode  = md;
            seed  = sd;
        end
    endtask

    initial begin
        // Reset then quiet idle.
        drv(3, 1, 0, 0, 2'd0, 32'd0);
        drv(5, 0, 0, 0, 2'd0, 32'd0);

        // Counter run; mode/seed wiggle afterwards must not affect the latched run.
        drv(1, 0, 1, 0, 2'd1, 32'd0);
        drv(11, 0, 0, 0, 2'd2, 32'h1234_5678);

        // LFSR from an all-zero seed.
        drv(1, 0, 1, 0, 2'd2, 32'd0);
        drv(10, 0, 0, 0, 2'd0, 32'd0);

        // Constant, truncated to the operand width.
        drv(1, 0, 1, 0, 2'd3, 32'hDEAD_BEEF);
        drv(10, 0, 0, 0, 2'd0, 32'd0);

        // Abort in frame 2 second cycle; start pulses during RUN are ignored.
        drv(1, 0, 1, 0, 2'd1, 32'd0);
        drv(2, 0, 1, 0, 2'd3, 32'hFFFF_0000);
        drv(3, 0, 0, 0, 2'd0, 32'd0);
        drv(1, 0, 0, 1, 2'd0, 32'd0);
        drv(4, 0, 0, 0, 2'd0, 32'd0);

        // Reset in the middle of an LFSR run.
        drv(1, 0, 1, 0, 2'd2, 32'hACE1_0F0F);
        drv(4, 0, 0, 0, 2'd0, 32'd0);
        drv(1, 1, 0, 0, 2'd0, 32'd0);
        drv(3, 0, 0, 0, 2'd0, 32'd0);

        // Back-to-back: start held high, second run must pick up the new seed.
        drv(1, 0, 1, 0, 2'd3, 32'h0000_AAAA);
        drv(10, 0, 1, 0, 2'd2, 32'h0BAD_F00D);
        drv(10, 0, 0, 0, 2'd0, 32'd0);

        // start and abort together in IDLE.
        drv(1, 0, 1, 1, 2'd1, 32'd0);
        drv(10, 0, 0, 0, 2'd0, 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bit          r_rst;
            bit          r_st;
            bit          r_ab;
            logic [31:0] r_sd;
            r_rst = ($urandom % 100) == 0;
            r_st  = ($urandom % 6) == 0;
            r_ab  = ($urandom % 15) == 0;
            r_sd  = (($urandom % 8) == 0) ? 32'd0 : $urandom;
            drv(1, r_rst, r_st, r_ab, 2'($urandom % 4), r_sd);
        end

        drv(3, 0, 0, 0, 2'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
